// File: rtl/alu_div.sv
// ---------------------------------------------------------------------------
// alu_div -- sequential restoring divider for the execution unit.
//
// Executes DIVU / DIV on byte (16/8) or word (32/16) operands. Signed
// operands are converted to magnitudes on accept, divided unsigned, and the
// signs are reapplied in FIX (quotient truncates toward zero, remainder takes
// the dividend's sign). Overflow and divide-by-zero raise div_error with done
// and leave quotient/remainder untouched.
//
// Optional feature (compile-time macro):
//   ALU_DIV_RADIX4_EN  -- retire two quotient bits per ITER cycle
//                         (word latency 11, byte 7 instead of 19 / 11).
//
// Ports:
//   clk        in   core clock
//   reset_n    in   synchronous active-low reset
//   start      in   request, accepted only while busy = 0
//   signed_op  in   1 = DIV (two's complement), 0 = DIVU
//   wide       in   1 = word (32/16), 0 = byte (dividend[15:0] / divisor[7:0])
//   dividend   in   [31:0] dividend, sampled on accept
//   divisor    in   [15:0] divisor, sampled on accept
//   busy       out  high in CHECK, ITER, FIX
//   done       out  one-cycle completion pulse
//   div_error  out  divide-by-zero or quotient overflow, valid with done
//   quotient   out  [15:0] result, byte results zero-extended
//   remainder  out  [15:0] result, byte results zero-extended
// ---------------------------------------------------------------------------
module alu_div (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic        wide,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_error,
    output logic [15:0] quotient,
    output logic [15:0] remainder
);

    typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;

    typedef struct packed {
        logic [15:0] rem;
        logic [15:0] quo;
    } step_t;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    // from the (n+1)-bit shifted remainder, shift the quotient bit into quo.
    function automatic step_t div_step(input logic [15:0] rem,
                                       input logic [15:0] quo,
                                       input logic [15:0] dvs);
        logic [16:0] shifted;
        step_t       res;
        shifted = {rem, quo[15]};
        if (shifted >= {1'b0, dvs}) begin
            res.rem = 16'(shifted - {1'b0, dvs});
            res.quo = {quo[14:0], 1'b1};
        end else begin
            res.rem = shifted[15:0];
            res.quo = {quo[14:0], 1'b0};
        end
        return res;
    endfunction

    state_t      state;
    logic        op_signed, op_wide, dvd_neg, dvs_neg;
    logic [31:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic [15:0] prem;    // partial remainder, always < divisor between steps
    logic [15:0] pquo;    // dividend bits shifting out, quotient bits shifting in
    logic [3:0]  count;
    logic        accept;

    // Operand magnitudes computed from the raw inputs on accept.
    logic        in_dvd_neg, in_dvs_neg;
    logic [31:0] in_dvd_mag, neg32_dvd;
    logic [15:0] in_dvs_mag, neg16_dvd, neg16_dvs;
    logic [7:0]  neg8_dvs;

    always_comb begin
        neg32_dvd = -dividend;
        neg16_dvd = -dividend[15:0];
        neg16_dvs = -divisor;
        neg8_dvs  = -divisor[7:0];
        if (wide) begin
            in_dvd_neg = signed_op & dividend[31];
            in_dvs_neg = signed_op & divisor[15];
            in_dvd_mag = in_dvd_neg ? neg32_dvd : dividend;
            in_dvs_mag = in_dvs_neg ? neg16_dvs : divisor;
        end else begin
            in_dvd_neg = signed_op & dividend[15];
            in_dvs_neg = signed_op & divisor[7];
            in_dvd_mag = {16'h0000, in_dvd_neg ? neg16_dvd : dividend[15:0]};
            in_dvs_mag = {8'h00, in_dvs_neg ? neg8_dvs : divisor[7:0]};
        end
    end

    // CHECK / ITER / FIX combinational terms.
    logic [15:0] upper, quo_mag_neg, rem_mag_neg, quo_res, rem_res;
    logic [15:0] fix_quo, fix_rem, pos_lim, neg_lim;
    logic        check_err, fix_err, quo_neg;
    step_t       step1, step_nxt;

    always_comb begin
        // Quotient fits in n bits only if the upper n dividend bits are
        // strictly below the divisor; this also catches divide-by-zero.
        upper     = op_wide ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
        check_err = (dvs_mag == 16'd0) || (upper >= dvs_mag);

        step1 = div_step(prem, pquo, dvs_mag);
`ifdef ALU_DIV_RADIX4_EN
        step_nxt = div_step(step1.rem, step1.quo, dvs_mag);
`else
        step_nxt = step1;
`endif

        quo_neg     = op_signed & (dvd_neg ^ dvs_neg);
        quo_mag_neg = -pquo;
        rem_mag_neg = -prem;
        quo_res     = quo_neg ? quo_mag_neg : pquo;
        rem_res     = dvd_neg ? rem_mag_neg : prem;
        fix_quo     = op_wide ? quo_res : {8'h00, quo_res[7:0]};
        fix_rem     = op_wide ? rem_res : {8'h00, rem_res[7:0]};
        // Negative results may reach -2^(n-1); positive ones stop one short.
        pos_lim     = op_wide ? 16'h7FFF : 16'h007F;
        neg_lim     = op_wide ? 16'h8000 : 16'h0080;
        fix_err     = op_signed & (quo_neg ? (pquo > neg_lim) : (pquo > pos_lim));
    end

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_error <= 1'b0;
            quotient  <= 16'h0000;
            remainder <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments throughout so every register
            // samples the pre-edge values; defaults make done a single pulse.
            done      <= 1'b0;
            div_error <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= CHECK;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    if (check_err) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        div_error <= 1'b1;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (count == 4'd0) state <= FIX;
                end
                FIX: begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    div_error <= fix_err;
                    if (!fix_err) begin
                        quotient  <= fix_quo;
                        remainder <= fix_rem;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; each is loaded on accept or
    // in CHECK before it is ever read, so a reset would only cost routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_signed <= signed_op;
            op_wide   <= wide;
            dvd_neg   <= in_dvd_neg;
            dvs_neg   <= in_dvs_neg;
            dvd_mag   <= in_dvd_mag;
            dvs_mag   <= in_dvs_mag;
        end
        case (state)
            CHECK: begin
                prem <= upper;
                // Byte dividends are MSB-aligned so every step shifts out bit 15.
                pquo <= op_wide ? dvd_mag[15:0] : {dvd_mag[7:0], 8'h00};
`ifdef ALU_DIV_RADIX4_EN
                count <= op_wide ? 4'd7 : 4'd3;
`else
                count <= op_wide ? 4'd15 : 4'd7;
`endif
            end
            ITER: begin
                prem  <= step_nxt.rem;
                pquo  <= step_nxt.quo;
                count <= count - 4'd1;
            end
            default: ;
        endcase
    end

endmodule
